// File: rtl/router_input_unit_if.sv
// Router input unit port bundle.
// Upstream link, lookahead stage and switch allocator signals.
interface router_input_unit_if #(
  parameter int DATA_W  = 64,
  parameter int COORD_W = 4,
  parameter int DIR_W   = 5
);
  logic [DATA_W-1:0]    data_in;
  logic                 data_in_valid;
  logic                 credit_out;
  logic [2*COORD_W-1:0] la_destination;
  logic [DIR_W-1:0]     la_current_routing;
  logic [DIR_W-1:0]     la_next_routing;
  logic [DATA_W-1:0]    data_out;
  logic                 data_out_valid;
  logic [DIR_W-1:0]     routing_out;
  logic                 data_out_ready;
  logic                 overflow_err;
  logic                 protocol_err;

  modport slave (
    input  data_in, data_in_valid,
    input  la_next_routing, data_out_ready,
    output credit_out, la_destination,
    output la_current_routing, data_out,
    output data_out_valid, routing_out,
    output overflow_err, protocol_err
  );

  modport master (
    output data_in, data_in_valid,
    output la_next_routing, data_out_ready,
    input  credit_out, la_destination,
    input  la_current_routing, data_out,
    input  data_out_valid, routing_out,
    input  overflow_err, protocol_err
  );
endinterface

// File: rtl/router_input_unit.sv
// Mesh router input port: credit-flow FIFO, per-packet route
// hold, lookahead routing hookup and header route rewrite.
module router_input_unit #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 64,
  parameter int COORD_W = 4,
  parameter int DIR_W   = 5
) (
  input  logic           clk,
  input  logic           rst,
  router_input_unit_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int RT_HI = DATA_W - 3;
  localparam int DS_HI = RT_HI - DIR_W;

  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_HDR  = 2'b10;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q;
  logic [DIR_W-1:0]     routing_q, routing_d;
  logic [2*COORD_W-1:0] la_dst_q, la_dst_d;
  logic [DIR_W-1:0]     la_cur_q, la_cur_d;
  logic                 credit_q, ovf_q, perr_q;

  logic [DATA_W-1:0]    head, dout;
  logic [1:0]           head_t;
  logic [DIR_W-1:0]     head_rt, rout;
  logic [2*COORD_W-1:0] head_dst;
  logic                 empty, full, is_hdr;
  logic                 valid, pop, drop, deq, enq;
  logic                 perr_set, ovf_set, la_upd;

  assign head     = mem_q[rd_ptr_q];
  assign head_t   = head[DATA_W-1 -: 2];
  assign head_rt  = head[RT_HI -: DIR_W];
  assign head_dst = head[DS_HI -: 2*COORD_W];
  assign is_hdr   = head_t[1];
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));

  // Head presentation, pop decision and packet FSM next state.
  always_comb begin
    state_d   = state_q;
    routing_d = routing_q;
    la_dst_d  = la_dst_q;
    la_cur_d  = la_cur_q;
    la_upd    = 1'b0;
    valid     = 1'b0;
    dout      = '0;
    rout      = '0;
    pop       = 1'b0;
    drop      = 1'b0;
    perr_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (is_hdr) begin
            valid    = 1'b1;
            rout     = head_rt;
            la_dst_d = head_dst;
            la_cur_d = head_rt;
            la_upd   = 1'b1;
            dout     = head;
            dout[RT_HI -: DIR_W] = bus.la_next_routing;
            pop      = bus.data_out_ready;
            if (pop && head_t == T_HDR) begin
              state_d   = ACTIVE;
              routing_d = head_rt;
            end
          end else begin
            drop     = 1'b1;
            perr_set = 1'b1;
          end
        end
      end
      ACTIVE: begin
        rout = routing_q;
        if (!empty) begin
          valid    = 1'b1;
          dout     = head;
          pop      = bus.data_out_ready;
          perr_set = is_hdr;
          if (pop && head_t == T_TAIL)
            state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  assign deq     = pop | drop;
  assign enq     = bus.data_in_valid & (!full | deq);
  assign ovf_set = bus.data_in_valid & full & !deq;

  // FIFO storage, pointers, sticky errors and packet state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      routing_q <= '0;
      la_dst_q  <= '0;
      la_cur_q  <= '0;
      credit_q  <= 1'b0;
      ovf_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      if (enq) begin
        mem_q[wr_ptr_q] <= bus.data_in;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (deq)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      if (enq && !deq)
        cnt_q <= cnt_q + CW'(1);
      else if (!enq && deq)
        cnt_q <= cnt_q - CW'(1);
      state_q   <= state_d;
      routing_q <= routing_d;
      if (la_upd) begin
        la_dst_q <= la_dst_d;
        la_cur_q <= la_cur_d;
      end
      credit_q <= deq;
      ovf_q    <= ovf_q | ovf_set;
      perr_q   <= perr_q | perr_set;
    end
  end

  assign bus.credit_out         = credit_q;
  assign bus.la_destination     = la_dst_d;
  assign bus.la_current_routing = la_cur_d;
  assign bus.data_out           = dout;
  assign bus.data_out_valid     = valid;
  assign bus.routing_out        = rout;
  assign bus.overflow_err       = ovf_q;
  assign bus.protocol_err       = perr_q;
endmodule

// File: tb/tb_router_input_unit.sv
// Bench for router_input_unit: queue-based packet model
// checked every cycle plus directed literal expectations.
module tb_router_input_unit;
  localparam int DEPTH   = 4;
  localparam int DATA_W  = 64;
  localparam int COORD_W = 4;
  localparam int DIR_W   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  router_input_unit_if #(
    .DATA_W(DATA_W), .COORD_W(COORD_W), .DIR_W(DIR_W)
  ) bus ();

  router_input_unit #(
    .DEPTH(DEPTH), .DATA_W(DATA_W),
    .COORD_W(COORD_W), .DIR_W(DIR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int ncred  = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(
    logic [1:0] t, logic [4:0] r,
    logic [3:0] x, logic [3:0] y, logic [48:0] pl);
    return {t, r, x, y, pl};
  endfunction

  // Model: flit queue plus "inside a packet" flag.
  logic [63:0] mq[$];
  bit          m_pkt;
  logic [4:0]  m_rq;
  logic [7:0]  m_ladst;
  logic [4:0]  m_lacur;
  bit          m_cred, m_ovf, m_perr;

  always @(negedge clk) begin : cmp
    logic [63:0] hd, e_dout;
    logic [1:0]  t;
    logic        e_valid, pop, drop, deq, ne;
    logic [4:0]  e_rout, e_cur;
    logic [7:0]  e_dst;
    if (rst) begin
      mq.delete();
      m_pkt = 0; m_rq = '0; m_ladst = '0; m_lacur = '0;
      m_cred = 0; m_ovf = 0; m_perr = 0;
      chk("rst_valid", 64'(bus.data_out_valid), 0);
      chk("rst_credit", 64'(bus.credit_out), 0);
      chk("rst_dout", bus.data_out, 0);
      chk("rst_rout", 64'(bus.routing_out), 0);
      chk("rst_ovf", 64'(bus.overflow_err), 0);
      chk("rst_perr", 64'(bus.protocol_err), 0);
    end else begin
      if (bus.credit_out) ncred++;
      ne = (mq.size() != 0);
      hd = ne ? mq[0] : '0;
      t  = hd[63:62];
      e_valid = 0; e_dout = '0; drop = 0;
      e_rout = m_pkt ? m_rq : 5'd0;
      e_dst = m_ladst; e_cur = m_lacur;
      if (ne && !m_pkt && t[1]) begin
        e_valid = 1;
        e_rout  = hd[61:57];
        e_dst   = hd[56:49];
        e_cur   = hd[61:57];
        e_dout  = hd;
        e_dout[61:57] = bus.la_next_routing;
      end else if (ne && !m_pkt) begin
        drop = 1;
      end else if (ne) begin
        e_valid = 1;
        e_dout  = hd;
      end
      chk("valid", 64'(bus.data_out_valid), 64'(e_valid));
      chk("dout", bus.data_out, e_dout);
      chk("rout", 64'(bus.routing_out), 64'(e_rout));
      chk("la_dst", 64'(bus.la_destination), 64'(e_dst));
      chk("la_cur", 64'(bus.la_current_routing),
          64'(e_cur));
      chk("credit", 64'(bus.credit_out), 64'(m_cred));
      chk("ovf", 64'(bus.overflow_err), 64'(m_ovf));
      chk("perr", 64'(bus.protocol_err), 64'(m_perr));
      pop = e_valid && bus.data_out_ready;
      deq = pop || drop;
      if (drop || (m_pkt && ne && t[1])) m_perr = 1;
      m_ladst = e_dst;
      m_lacur = e_cur;
      if (pop) begin
        if (!m_pkt && t == 2'b10) begin
          m_pkt = 1;
          m_rq  = hd[61:57];
        end else if (m_pkt && t == 2'b01) begin
          m_pkt = 0;
        end
      end
      if (bus.data_in_valid) begin
        if (mq.size() < DEPTH || deq)
          mq.push_back(bus.data_in);
        else
          m_ovf = 1;
      end
      if (deq) void'(mq.pop_front());
      m_cred = deq;
    end
  end

  task automatic drive(logic v, logic [63:0] d, logic rdy);
    @(posedge clk);
    #1;
    bus.data_in_valid  = v;
    bus.data_in        = d;
    bus.data_out_ready = rdy;
  endtask

  task automatic idle(int n, logic rdy);
    for (int i = 0; i < n; i++) drive(0, '0, rdy);
  endtask

  logic [63:0] H, B, T, HT;
  int c0;

  initial begin
    rst = 1'b1;
    bus.data_in_valid   = 0;
    bus.data_in         = '0;
    bus.data_out_ready  = 0;
    bus.la_next_routing = 5'b00100;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2, 1);

    H = mk(2'b10, 5'b00010, 4'd3, 4'd1, 49'h1111);
    B = mk(2'b00, 5'b00000, 4'd0, 4'd0, 49'h2222);
    T = mk(2'b01, 5'b00000, 4'd0, 4'd0, 49'h3333);

    // Header/body/tail stream.
    c0 = ncred;
    drive(1, H, 1);
    drive(1, B, 1);
    @(negedge clk);
    chk("t1_hdr_dout", bus.data_out,
        mk(2'b10, 5'b00100, 4'd3, 4'd1, 49'h1111));
    chk("t1_hdr_rout", 64'(bus.routing_out), 64'h02);
    chk("t1_la_dst", 64'(bus.la_destination), 64'h31);
    drive(1, T, 1);
    @(negedge clk);
    chk("t1_body_rout", 64'(bus.routing_out), 64'h02);
    chk("t1_body_dout", bus.data_out, B);
    idle(4, 1);
    chk("t1_credits", 64'(ncred - c0), 3);

    // Full FIFO with simultaneous push/pop, pointer wrap.
    c0 = ncred;
    for (int k = 0; k < 10; k++) begin
      logic rdy;
      logic [4:0] r;
      rdy = (k >= 2);
      r = 5'(1 << (k % 5));
      drive(1, mk(2'b10, r, 4'(k), 4'(k + 1), 49'(k)), rdy);
      drive(1, mk(2'b01, 5'd0, 4'd0, 4'd0, 49'(k + 100)),
            rdy);
    end
    idle(6, 1);
    chk("t3_no_ovf", 64'(bus.overflow_err), 0);
    chk("t3_credits", 64'(ncred - c0), 20);

    // Headtail alone, then a normal header.
    c0 = ncred;
    HT = mk(2'b11, 5'b00001, 4'd5, 4'd6, 49'hAAA);
    bus.la_next_routing = 5'b01000;
    drive(1, HT, 0);
    drive(0, '0, 0);
    @(negedge clk);
    chk("ht_dout", bus.data_out,
        mk(2'b11, 5'b01000, 4'd5, 4'd6, 49'hAAA));
    chk("ht_rout", 64'(bus.routing_out), 64'h01);
    idle(2, 1);
    bus.la_next_routing = 5'b00100;
    drive(1, H, 1);
    drive(1, T, 1);
    idle(3, 1);
    chk("ht_credits", 64'(ncred - c0), 3);

    // Overflow with ready low, then drain.
    drive(1, H, 0);
    drive(1, B, 0);
    drive(1, B, 0);
    drive(1, T, 0);
    drive(1, mk(2'b00, 5'd0, 4'd0, 4'd0, 49'h5555), 0);
    drive(0, '0, 0);
    @(negedge clk);
    chk("ovf_set", 64'(bus.overflow_err), 1);
    chk("ovf_head", bus.data_out,
        mk(2'b10, 5'b00100, 4'd3, 4'd1, 49'h1111));
    c0 = ncred;
    idle(6, 1);
    chk("ovf_credits", 64'(ncred - c0), 4);

    // Body in IDLE is dropped with a protocol error.
    chk("perr_before", 64'(bus.protocol_err), 0);
    c0 = ncred;
    drive(1, B, 1);
    drive(0, '0, 1);
    @(negedge clk);
    chk("perr_body_valid", 64'(bus.data_out_valid), 0);
    idle(2, 1);
    chk("perr_set", 64'(bus.protocol_err), 1);
    chk("perr_credits", 64'(ncred - c0), 1);

    // Reset mid-packet.
    drive(1, H, 0);
    drive(1, B, 0);
    drive(1, B, 0);
    drive(0, '0, 1);
    drive(0, '0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.data_out_valid), 0);
    chk("arst_dout", bus.data_out, 0);
    chk("arst_rout", 64'(bus.routing_out), 0);
    chk("arst_ovf", 64'(bus.overflow_err), 0);
    chk("arst_perr", 64'(bus.protocol_err), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, H, 1);
    drive(0, '0, 1);
    @(negedge clk);
    chk("post_rst_hdr", bus.data_out,
        mk(2'b10, 5'b00100, 4'd3, 4'd1, 49'h1111));
    chk("post_rst_valid", 64'(bus.data_out_valid), 1);
    idle(3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
